sdram_frame_writer: RTL and testbench
=====================================

Name: sdram_frame_writer

Overview:
- Upstream neighbour of the SDRAM frame reader. Takes a 64-bit pixel-word stream (8 bytes = 2 pixels at 32 bpp) with a start-of-frame marker.
- Packs the stream into fixed-length Avalon-MM burst writes into frame buffer 0 in SDRAM.
- Wraps the address at the end of each 1080p frame.
- Raises frame_ready_o once a complete frame is resident, which the reader uses to start fetching.

Parameters:
- SDRAM_DATA_WIDTH, 64: Avalon data width in bits; byteenable width is SDRAM_DATA_WIDTH/8.
- BURST_LEN, 8: words per Avalon write burst; range 1..128; must divide FRAME_WORDS exactly.
- BUFFER_BYTE_ADDR, 32'h2000_0000: byte base of frame buffer 0. Word base is BUFFER_BYTE_ADDR/(SDRAM_DATA_WIDTH/8) = 0x400_0000.
- FRAME_WORDS, 1036800 (0xFD200): words per 1920x1080x32bpp frame.

Ports:
- sdram_clk, in, 1: single clock for the whole block.
- rst, in, 1: synchronous, active-high reset.
- enable_i, in, 1: allows new bursts to start; a burst already in progress always completes.
- pix_data_i, in, SDRAM_DATA_WIDTH: pixel word.
- pix_valid_i, in, 1: pix_data_i and pix_sof_i are valid.
- pix_sof_i, in, 1: marks the current word as word 0 of a frame.
- pix_ready_o, out, 1: word accepted on a cycle with pix_valid_i & pix_ready_o.
- sdram_address_o, out, 29: Avalon word address of the current burst.
- sdram_burstcount_o, out, 8: constant BURST_LEN.
- sdram_writedata_o, out, SDRAM_DATA_WIDTH: write data.
- sdram_byteenable_o, out, SDRAM_DATA_WIDTH/8: all ones.
- sdram_write_o, out, 1: Avalon write.
- sdram_waitrequest_i, in, 1: Avalon slave stall.
- frame_ready_o, out, 1: sticky; at least one full frame has been written.
- frame_count_o, out, 16: completed frames; wraps 0xFFFF -> 0.
- sof_error_o, out, 1: sticky; sof_i was misplaced.

Behaviour:
- Reset (any cycle, including mid-burst; the Avalon burst is abandoned):
  - state = SYNC, sdram_address_o = 0x400_0000, word_idx = 0, beat_cnt = 0.
  - sdram_write_o = 0, frame_ready_o = 0, frame_count_o = 0, sof_error_o = 0.
- SYNC:
  - pix_ready_o = ~(pix_valid_i & pix_sof_i). Non-SOF words are consumed and dropped.
  - On pix_valid_i & pix_sof_i, go to IDLE next cycle without consuming the word.
  - sdram_write_o = 0.
- IDLE:
  - pix_ready_o = 0, sdram_write_o = 0.
  - If enable_i & pix_valid_i, go to BURST next cycle with beat_cnt = 0.
  - sdram_address_o is already valid; it is registered and changes only at burst end.
- BURST (beats are combinational pass-through of the stream):
  - sdram_write_o = pix_valid_i; sdram_writedata_o = pix_data_i; pix_ready_o = ~sdram_waitrequest_i.
  - A beat is accepted when pix_valid_i & ~sdram_waitrequest_i; beat_cnt then increments.
  - sdram_address_o and sdram_burstcount_o are held constant for the whole burst.
  - Gaps (pix_valid_i = 0) are legal mid-burst and hold beat_cnt.
  - enable_i is ignored while in BURST.
- Last beat (beat_cnt == BURST_LEN-1, accepted):
  - Go to IDLE; word_idx += BURST_LEN; sdram_address_o += BURST_LEN.
  - If word_idx + BURST_LEN == FRAME_WORDS: word_idx <= 0, sdram_address_o <= 0x400_0000, frame_count_o += 1, frame_ready_o <= 1.
  - Last burst address is 0x40F_D1F8 with the default parameters.
- SOF checks, on each accepted beat:
  - pix_sof_i = 1 with (word_idx + beat_cnt) != 0: set sof_error_o.
  - pix_sof_i = 0 with (word_idx + beat_cnt) == 0: set sof_error_o.
  - No resynchronisation in either case; the write sequence continues unchanged.
- Latency: zero-cycle pass-through of data and valid, plus one IDLE cycle between bursts. Throughput is therefore BURST_LEN/(BURST_LEN+1) with no stalls.
- Word width: word_idx is 20 bits. sdram_address_o arithmetic is 29-bit and never exceeds base + FRAME_WORDS - BURST_LEN.
- Simultaneous events: on a cycle where the wrap happens, frame_count_o and frame_ready_o update together with the address wrap. A sof error on that same cycle is still flagged.

Decomposition:
- Package sdram_frame_pkg holds:
  - FRAME_WORDS_1080P = 1036800;
  - BUFFER0_BYTE_ADDR = 32'h2000_0000;
  - word-base function (byte addr, data width);
  - typedef enum logic [1:0] {SYNC, IDLE, BURST} wr_state_t.
- The reader block shares the package for the same base and frame size.
- No sub-module: a single FSM with counters.

Test Plan:
- Reset, stream 3 non-SOF words, then SOF word 0xA5 -> the 3 words are dropped (pix_ready_o = 1). The first burst starts at address 0x400_0000 with writedata 0xA5 and burstcount 8.
- Continuous valid, no waitrequest, 16 words -> two bursts at 0x400_0000 and 0x400_0008. sdram_write_o is high 8 cycles, low 1 cycle, high 8 cycles.
- waitrequest held high 3 cycles on beat 4 -> pix_ready_o = 0 for those cycles, data and address are held, and no word is lost or duplicated. Insert a pix_valid_i gap mid-burst -> beat count is held.
- Full frame of 1036800 words (parameter may be overridden to FRAME_WORDS = 64 for speed) -> the last burst is at base + FRAME_WORDS - 8. Then address returns to 0x400_0000, frame_count_o = 1, frame_ready_o = 1.
- SOF asserted at word 5 -> sof_error_o = 1 and stays set; addresses are unaffected.
- rst asserted mid-burst at beat 3 -> the next cycle has sdram_write_o = 0 and state SYNC. frame_ready_o, frame_count_o and sof_error_o are all 0.

Source files
------------

// File: rtl/sdram_frame_pkg.sv
// Shared definitions for the SDRAM frame writer and reader: frame geometry,
// frame buffer 0 placement and the writer FSM state type.
package sdram_frame_pkg;

    localparam int unsigned FRAME_WORDS_1080P = 1036800;
    localparam logic [31:0] BUFFER0_BYTE_ADDR = 32'h2000_0000;
    localparam int unsigned SDRAM_ADDR_W      = 29;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        IDLE  = 2'd1,
        BURST = 2'd2
    } wr_state_t;

    // Avalon word address of a byte address for a given bus data width.
    function automatic logic [SDRAM_ADDR_W-1:0] word_base(
        input logic [31:0] byte_addr,
        input int unsigned data_width
    );
        return SDRAM_ADDR_W'(byte_addr / 32'(data_width / 8));
    endfunction

endpackage

// File: rtl/sdram_frame_writer.sv
// Packs a 64-bit pixel-word stream into fixed-length Avalon-MM write bursts
// into frame buffer 0, wrapping at the end of each frame.
module sdram_frame_writer
    import sdram_frame_pkg::*;
#(
    parameter int unsigned SDRAM_DATA_WIDTH = 64,
    parameter int unsigned BURST_LEN        = 8,
    parameter logic [31:0] BUFFER_BYTE_ADDR = BUFFER0_BYTE_ADDR,
    parameter int unsigned FRAME_WORDS      = FRAME_WORDS_1080P
) (
    input  logic                          sdram_clk,
    input  logic                          rst,
    input  logic                          enable_i,
    input  logic [SDRAM_DATA_WIDTH-1:0]   pix_data_i,
    input  logic                          pix_valid_i,
    input  logic                          pix_sof_i,
    output logic                          pix_ready_o,
    output logic [28:0]                   sdram_address_o,
    output logic [7:0]                    sdram_burstcount_o,
    output logic [SDRAM_DATA_WIDTH-1:0]   sdram_writedata_o,
    output logic [SDRAM_DATA_WIDTH/8-1:0] sdram_byteenable_o,
    output logic                          sdram_write_o,
    input  logic                          sdram_waitrequest_i,
    output logic                          frame_ready_o,
    output logic [15:0]                   frame_count_o,
    output logic                          sof_error_o
);

    localparam logic [28:0] WORD_BASE = word_base(BUFFER_BYTE_ADDR, SDRAM_DATA_WIDTH);
    localparam int unsigned BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [20:0]       BURST_STEP = 21'(BURST_LEN);
    localparam logic [20:0]       FRAME_END  = 21'(FRAME_WORDS);

    wr_state_t          state_q, state_d;
    logic [28:0]        addr_q, addr_d;
    logic [19:0]        word_idx_q, word_idx_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               frame_ready_q, frame_ready_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               sof_err_q, sof_err_d;

    logic beat_acc;
    logic frame_end;
    logic at_frame_start;

    assign beat_acc       = (state_q == BURST) & pix_valid_i & ~sdram_waitrequest_i;
    assign frame_end      = ({1'b0, word_idx_q} + BURST_STEP) == FRAME_END;
    // word_idx is a multiple of BURST_LEN, so the sum is zero only when both are.
    assign at_frame_start = (word_idx_q == 20'd0) && (beat_q == '0);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        word_idx_d    = word_idx_q;
        beat_d        = beat_q;
        frame_ready_d = frame_ready_q;
        frame_count_d = frame_count_q;
        sof_err_d     = sof_err_q;
        case (state_q)
            SYNC: begin
                if (pix_valid_i & pix_sof_i) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (enable_i & pix_valid_i) begin
                    state_d = BURST;
                    beat_d  = '0;
                end
            end
            BURST: begin
                if (beat_acc) begin
                    if (pix_sof_i != at_frame_start) begin
                        sof_err_d = 1'b1;
                    end
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                        if (frame_end) begin
                            word_idx_d    = 20'd0;
                            addr_d        = WORD_BASE;
                            frame_count_d = frame_count_q + 16'd1;
                            frame_ready_d = 1'b1;
                        end else begin
                            word_idx_d = word_idx_q + 20'(BURST_LEN);
                            addr_d     = addr_q + 29'(BURST_LEN);
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            state_q       <= SYNC;
            addr_q        <= WORD_BASE;
            word_idx_q    <= 20'd0;
            beat_q        <= '0;
            frame_ready_q <= 1'b0;
            frame_count_q <= 16'd0;
            sof_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            word_idx_q    <= word_idx_d;
            beat_q        <= beat_d;
            frame_ready_q <= frame_ready_d;
            frame_count_q <= frame_count_d;
            sof_err_q     <= sof_err_d;
        end
    end

    // Hunting for SOF drops everything else; bursts pass the stream straight through.
    always_comb begin
        pix_ready_o = 1'b0;
        case (state_q)
            SYNC:    pix_ready_o = ~(pix_valid_i & pix_sof_i);
            BURST:   pix_ready_o = ~sdram_waitrequest_i;
            default: pix_ready_o = 1'b0;
        endcase
    end

    assign sdram_write_o      = (state_q == BURST) & pix_valid_i;
    assign sdram_writedata_o  = pix_data_i;
    assign sdram_address_o    = addr_q;
    assign sdram_burstcount_o = 8'(BURST_LEN);
    assign sdram_byteenable_o = '1;
    assign frame_ready_o      = frame_ready_q;
    assign frame_count_o      = frame_count_q;
    assign sof_error_o        = sof_err_q;

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Randomised self-checking bench for sdram_frame_writer (short 64-word frame),
// compared each cycle against a word-count based reference model.
module tb_sdram_frame_writer;

    localparam int DW = 64;
    localparam int BL = 8;
    localparam int FW = 64;
    localparam logic [28:0] BASE = 29'h400_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_i;
    logic [DW-1:0] pix_data_i;
    logic          pix_valid_i;
    logic          pix_sof_i;
    logic          pix_ready_o;
    logic [28:0]   sdram_address_o;
    logic [7:0]    sdram_burstcount_o;
    logic [DW-1:0] sdram_writedata_o;
    logic [7:0]    sdram_byteenable_o;
    logic          sdram_write_o;
    logic          sdram_waitrequest_i;
    logic          frame_ready_o;
    logic [15:0]   frame_count_o;
    logic          sof_error_o;

    always #5 clk = ~clk;

    sdram_frame_writer #(
        .SDRAM_DATA_WIDTH (DW),
        .BURST_LEN        (BL),
        .BUFFER_BYTE_ADDR (32'h2000_0000),
        .FRAME_WORDS      (FW)
    ) dut (
        .sdram_clk           (clk),
        .rst                 (rst),
        .enable_i            (enable_i),
        .pix_data_i          (pix_data_i),
        .pix_valid_i         (pix_valid_i),
        .pix_sof_i           (pix_sof_i),
        .pix_ready_o         (pix_ready_o),
        .sdram_address_o     (sdram_address_o),
        .sdram_burstcount_o  (sdram_burstcount_o),
        .sdram_writedata_o   (sdram_writedata_o),
        .sdram_byteenable_o  (sdram_byteenable_o),
        .sdram_write_o       (sdram_write_o),
        .sdram_waitrequest_i (sdram_waitrequest_i),
        .frame_ready_o       (frame_ready_o),
        .frame_count_o       (frame_count_o),
        .sof_error_o         (sof_error_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words accepted since sync determine address, frame count and SOF expectations.
    bit     m_known = 0;
    bit     m_sync, m_active, m_err;
    longint m_n;

    always @(negedge clk) begin : monitor
        logic [28:0] e_addr;
        logic        e_ready;
        logic        e_write;
        if (m_known) begin
            e_addr  = BASE + 29'(((m_n / BL) * BL) % FW);
            e_write = m_active && pix_valid_i;
            if (!m_sync)       e_ready = !(pix_valid_i && pix_sof_i);
            else if (m_active) e_ready = !sdram_waitrequest_i;
            else               e_ready = 1'b0;
            chk("address", sdram_address_o, e_addr);
            chk("write", sdram_write_o, e_write);
            chk("ready", pix_ready_o, e_ready);
            chk("frame_count", frame_count_o, 16'(m_n / FW));
            chk("frame_ready", frame_ready_o, m_n >= FW);
            chk("sof_error", sof_error_o, m_err);
            chk("burstcount", sdram_burstcount_o, 8'd8);
            chk("byteenable", sdram_byteenable_o, 8'hFF);
            if (e_write) chk("writedata", sdram_writedata_o, pix_data_i);
        end
        if (rst) begin
            m_known = 1; m_sync = 0; m_active = 0; m_err = 0; m_n = 0;
        end else if (!m_sync) begin
            if (pix_valid_i && pix_sof_i) m_sync = 1;
        end else if (!m_active) begin
            if (enable_i && pix_valid_i) m_active = 1;
        end else if (pix_valid_i && !sdram_waitrequest_i) begin
            if (pix_sof_i != ((m_n % FW) == 0)) m_err = 1;
            m_n++;
            if ((m_n % BL) == 0) m_active = 0;
        end
    end

    // Stream source: holds each word until accepted; SOF marks frame position 0.
    int unsigned src_idx = 0;
    logic [63:0] src_data = 64'd0;
    bit          src_valid = 0;
    bit          acc_s;
    bit          a5_next = 0;
    bit          inj_armed = 0;
    int unsigned inj_pos = 5;

    task automatic tick();
        @(negedge clk);
        acc_s = pix_valid_i && pix_ready_o;
        @(posedge clk);
        #1;
    endtask

    task automatic src_cycle(input int pv, input int pw, input int pe);
        tick();
        if (acc_s) begin
            src_idx   = (src_idx + 1) % FW;
            src_valid = 0;
        end
        if (!src_valid && $urandom_range(99) < pv) begin
            src_valid = 1;
            src_data  = {$urandom, $urandom};
            if (a5_next && src_idx == 0) begin
                src_data = 64'hA5;
                a5_next  = 0;
            end
        end
        pix_valid_i         = src_valid;
        pix_data_i          = src_data;
        pix_sof_i           = src_valid && ((src_idx == 0) ^ (inj_armed && src_idx == inj_pos));
        sdram_waitrequest_i = ($urandom_range(99) < pw);
        enable_i            = ($urandom_range(99) < pe);
    endtask

    initial begin
        logic [4:0]  rtr;
        logic [17:0] wtr;
        logic [63:0] d5;
        logic [28:0] a5, a14, last_addr;
        logic [7:0]  bc5;
        bit          got, prev_wr;
        rtr = '0; wtr = '0; d5 = '0; a5 = '0; a14 = '0; bc5 = '0; last_addr = '0;

        rst = 1; enable_i = 0; pix_data_i = '0; pix_valid_i = 0; pix_sof_i = 0;
        sdram_waitrequest_i = 0;
        repeat (3) tick();
        #1;
        chk("rst_address", sdram_address_o, 29'h400_0000);
        chk("rst_write", sdram_write_o, 1'b0);
        chk("rst_frame_ready", frame_ready_o, 1'b0);
        chk("rst_frame_count", frame_count_o, 16'd0);
        chk("rst_sof_error", sof_error_o, 1'b0);
        rst = 0;

        // Three non-SOF words get dropped, then SOF word 0xA5 opens two back-to-back bursts.
        src_idx = FW - 3; a5_next = 1;
        for (int k = 0; k < 22; k++) begin
            src_cycle(100, 0, 100);
            #1;
            if (k < 5)  rtr = {rtr[3:0], pix_ready_o};
            if (k >= 4) wtr = {wtr[16:0], sdram_write_o};
            if (k == 5) begin d5 = sdram_writedata_o; a5 = sdram_address_o; bc5 = sdram_burstcount_o; end
            if (k == 14) a14 = sdram_address_o;
        end
        chk("sync_ready_trace", rtr, 5'b11100);
        chk("first_wdata", d5, 64'hA5);
        chk("first_addr", a5, 29'h400_0000);
        chk("first_burstcount", bc5, 8'd8);
        chk("write_trace", wtr, 18'b011111111011111111);
        chk("second_addr", a14, 29'h400_0008);

        // Third burst: stall three cycles on beat 4, then a valid gap.
        repeat (5) src_cycle(100, 0, 100);
        for (int k = 0; k < 3; k++) begin
            src_cycle(100, 100, 100);
            #1;
            chk("stall_ready", pix_ready_o, 1'b0);
            chk("stall_addr", sdram_address_o, 29'h400_0010);
            chk("stall_write", sdram_write_o, 1'b1);
        end
        src_cycle(100, 0, 100);
        pix_valid_i = 0; pix_sof_i = 0;
        #1;
        chk("gap_write", sdram_write_o, 1'b0);

        // Run to the first frame wrap.
        got = 0;
        for (int k = 0; k < 3000; k++) begin
            src_cycle(80, 20, 90);
            #1;
            if (frame_count_o == 16'd1) begin got = 1; break; end
            if (sdram_write_o) last_addr = sdram_address_o;
        end
        chk("wrap_seen", got, 1'b1);
        chk("last_burst_addr", last_addr, 29'h400_0038);
        chk("wrap_addr", sdram_address_o, 29'h400_0000);
        chk("wrap_frame_ready", frame_ready_o, 1'b1);

        // Misplaced SOF at frame word 5.
        inj_armed = 1; inj_pos = 5; got = 0;
        for (int k = 0; k < 1000; k++) begin
            src_cycle(90, 10, 100);
            #1;
            if (sof_error_o) begin got = 1; break; end
        end
        chk("sof_error_set", got, 1'b1);
        inj_armed = 0;
        repeat (50) src_cycle(90, 10, 100);
        #1;
        chk("sof_error_sticky", sof_error_o, 1'b1);

        // Reset while beat 3 of a burst is on the bus.
        got = 0; prev_wr = 1;
        for (int k = 0; k < 300; k++) begin
            src_cycle(100, 0, 100);
            #1;
            if (sdram_write_o && !prev_wr) begin got = 1; break; end
            prev_wr = sdram_write_o;
        end
        chk("burst_start_seen", got, 1'b1);
        repeat (3) src_cycle(100, 0, 100);
        rst = 1;
        src_cycle(100, 0, 100);
        rst = 0;
        #1;
        chk("midrst_write", sdram_write_o, 1'b0);
        chk("midrst_frame_ready", frame_ready_o, 1'b0);
        chk("midrst_frame_count", frame_count_o, 16'd0);
        chk("midrst_sof_error", sof_error_o, 1'b0);
        chk("midrst_addr", sdram_address_o, 29'h400_0000);

        // Free-running random traffic with occasional resets and SOF faults.
        for (int k = 0; k < 4000; k++) begin
            if ((k % 500) == 0) inj_armed = ($urandom_range(3) == 0);
            inj_pos = $urandom_range(FW - 1);
            src_cycle($urandom_range(100, 50), $urandom_range(40), $urandom_range(100, 70));
            rst = ($urandom_range(399) == 0);
        end
        rst = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
